flit_injector: RTL and testbench

- Upstream traffic source for the adder characterization harness.
- Generates packets of 2N-bit flits from a selectable deterministic pattern and splits each flit into two N-bit operands (low half → operand_a, high half → operand_b) that drive the adder inputs.
- Packet length, inter-packet idle gap, packet count and valid/ready back-pressure are all controlled in hardware, so switching-activity runs are reproducible without testbench tasks.

---
 rtl/flit_injector.sv | 202 ++++++++++++++++++++
 tb/tb_flit_injector.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/flit_injector.sv
// Packet/flit traffic source for the adder characterization harness.
// Each 2N-bit flit is split into two N-bit adder operands, with valid/ready handshaking.
module flit_injector #(
    parameter int unsigned    N        = 17,
    parameter int unsigned    PAYLOAD  = 20,
    parameter int unsigned    GAP      = 7,
    parameter int unsigned    NUM_PKTS = 10,
    parameter logic [2*N-1:0] SEED     = 34'h000000001,
    parameter logic [2*N-1:0] TAPS     = 34'h204000003
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [1:0]   mode,
    input  logic         ready,
    output logic [N-1:0] operand_a,
    output logic [N-1:0] operand_b,
    output logic         valid,
    output logic         sop,
    output logic         eop,
    output logic         busy,
    output logic         done
);

    localparam int unsigned W      = 2 * N;
    localparam int unsigned WT     = W + 1;
    localparam int unsigned FLIT_W = (PAYLOAD > 1) ? $clog2(PAYLOAD) : 1;
    localparam int unsigned PKT_W  = (NUM_PKTS > 1) ? $clog2(NUM_PKTS) : 1;
    localparam int unsigned GAP_W  = (GAP > 1) ? $clog2(GAP) : 1;

    localparam logic [1:0] MODE_LFSR  = 2'd0;
    localparam logic [1:0] MODE_THERM = 2'd1;
    localparam logic [1:0] MODE_ALT   = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [1:0]          mode_q, mode_d;
    logic [W-1:0]        lfsr_q, lfsr_d;
    logic [W-1:0]        lfsr_next;
    logic [FLIT_W-1:0]   flit_cnt_q, flit_cnt_d;
    logic [PKT_W-1:0]    pkt_cnt_q, pkt_cnt_d;
    logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;
    logic [W-1:0]        flit_q, flit_d;
    logic                valid_q, valid_d;
    logic                sop_q, sop_d;
    logic                eop_q, eop_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [31:0]         k_next;

    // Flit value for pattern md at in-packet index k, given the current LFSR state.
    function automatic logic [W-1:0] pattern(input logic [1:0] md, input logic [31:0] k,
                                             input logic [W-1:0] lfsr);
        logic [WT-1:0] therm;
        therm = (WT'(1) << (k % WT)) - WT'(1);
        unique case (md)
            MODE_LFSR:  pattern = lfsr;
            MODE_THERM: pattern = therm[W-1:0];
            MODE_ALT:   pattern = k[0] ? {W{1'b1}} : {W{1'b0}};
            default:    pattern = {W{1'b0}};
        endcase
    endfunction

    assign lfsr_next = {lfsr_q[W-2:0], ^(lfsr_q & TAPS)};
    assign k_next    = 32'(flit_cnt_q) + 32'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            mode_q     <= 2'd0;
            lfsr_q     <= SEED;
            flit_cnt_q <= '0;
            pkt_cnt_q  <= '0;
            gap_cnt_q  <= '0;
            flit_q     <= '0;
            valid_q    <= 1'b0;
            sop_q      <= 1'b0;
            eop_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            lfsr_q     <= lfsr_d;
            flit_cnt_q <= flit_cnt_d;
            pkt_cnt_q  <= pkt_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            flit_q     <= flit_d;
            valid_q    <= valid_d;
            sop_q      <= sop_d;
            eop_q      <= eop_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // Next state plus next registered outputs; operands hold whenever no new flit is loaded.
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        lfsr_d     = lfsr_q;
        flit_cnt_d = flit_cnt_q;
        pkt_cnt_d  = pkt_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        flit_d     = flit_q;
        valid_d    = 1'b0;
        sop_d      = 1'b0;
        eop_d      = 1'b0;
        busy_d     = 1'b0;
        done_d     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_SEND;
                    mode_d     = mode;
                    lfsr_d     = SEED;
                    flit_cnt_d = '0;
                    pkt_cnt_d  = '0;
                    gap_cnt_d  = '0;
                    flit_d     = pattern(mode, 32'd0, SEED);
                    valid_d    = 1'b1;
                    sop_d      = 1'b1;
                    eop_d      = (PAYLOAD == 1);
                    busy_d     = 1'b1;
                end
            end
            ST_SEND: begin
                valid_d = 1'b1;
                sop_d   = sop_q;
                eop_d   = eop_q;
                busy_d  = 1'b1;
                if (ready) begin
                    lfsr_d = lfsr_next;
                    if (32'(flit_cnt_q) == PAYLOAD - 1) begin
                        flit_cnt_d = '0;
                        if (32'(pkt_cnt_q) == NUM_PKTS - 1) begin
                            state_d = ST_DONE;
                            valid_d = 1'b0;
                            sop_d   = 1'b0;
                            eop_d   = 1'b0;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end else begin
                            pkt_cnt_d = pkt_cnt_q + PKT_W'(1);
                            if (GAP > 0) begin
                                state_d   = ST_GAP;
                                gap_cnt_d = '0;
                                valid_d   = 1'b0;
                                sop_d     = 1'b0;
                                eop_d     = 1'b0;
                            end else begin
                                flit_d = pattern(mode_q, 32'd0, lfsr_next);
                                sop_d  = 1'b1;
                                eop_d  = (PAYLOAD == 1);
                            end
                        end
                    end else begin
                        flit_cnt_d = flit_cnt_q + FLIT_W'(1);
                        flit_d     = pattern(mode_q, k_next, lfsr_next);
                        sop_d      = 1'b0;
                        eop_d      = (k_next == PAYLOAD - 1);
                    end
                end
            end
            ST_GAP: begin
                busy_d = 1'b1;
                if (32'(gap_cnt_q) == GAP - 1) begin
                    state_d   = ST_SEND;
                    gap_cnt_d = '0;
                    flit_d    = pattern(mode_q, 32'd0, lfsr_q);
                    valid_d   = 1'b1;
                    sop_d     = 1'b1;
                    eop_d     = (PAYLOAD == 1);
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign operand_a = flit_q[N-1:0];
    assign operand_b = flit_q[W-1:N];
    assign valid     = valid_q;
    assign sop       = sop_q;
    assign eop       = eop_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_flit_injector.sv
// Self-checking bench for flit_injector: per-cycle comparison against a flit-stream
// model plus hand-computed expectations for the key timing and pattern points.
module tb_flit_injector;

    localparam int unsigned N        = 17;
    localparam int unsigned W        = 2 * N;
    localparam int unsigned PAYLOAD  = 20;
    localparam int unsigned GAP      = 7;
    localparam int unsigned NUM_PKTS = 10;
    localparam int unsigned TOTAL    = PAYLOAD * NUM_PKTS;
    localparam logic [W-1:0] SEED    = 34'h000000001;
    localparam logic [W-1:0] TAPS    = 34'h204000003;
    localparam int MAXREC            = 600;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [1:0]   mode = 2'd0;
    logic         ready = 1'b1;
    logic [N-1:0] operand_a, operand_b;
    logic         valid, sop, eop, busy, done;

    int total = 0;
    int bad   = 0;

    flit_injector #(
        .N(N), .PAYLOAD(PAYLOAD), .GAP(GAP), .NUM_PKTS(NUM_PKTS), .SEED(SEED), .TAPS(TAPS)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .ready(ready),
        .operand_a(operand_a), .operand_b(operand_b),
        .valid(valid), .sop(sop), .eop(eop), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, want, $time);
        end
    endtask

    // ---------------- reference model: a run is a stream of TOTAL flits with gaps ----------------
    bit          m_active, m_done;
    int          m_idx, m_gap;
    logic [W-1:0] m_lfsr, m_flit;
    logic [1:0]  m_mode;
    bit          e_valid, e_sop, e_eop, e_busy, e_done;

    function automatic logic [W-1:0] lfsr_adv(input logic [W-1:0] s);
        bit fb = 1'b0;
        for (int i = 0; i < int'(W); i++)
            if (TAPS[i]) fb = fb ^ s[i];
        return {s[W-2:0], fb};
    endfunction

    function automatic logic [W-1:0] pat(input logic [1:0] md, input int k, input logic [W-1:0] s);
        logic [W-1:0] f = '0;
        case (md)
            2'd0: f = s;
            2'd1: for (int i = 0; i < k % (int'(W) + 1); i++) f[i] = 1'b1;
            2'd2: f = (k % 2 == 1) ? {W{1'b1}} : {W{1'b0}};
            default: f = '0;
        endcase
        return f;
    endfunction

    task automatic model_step(input bit r, input bit s, input logic [1:0] md, input bit rd);
        if (r) begin
            m_active = 0; m_done = 0; m_idx = 0; m_gap = 0;
            m_lfsr = SEED; m_flit = '0; m_mode = 2'd0;
        end else if (m_done) begin
            m_done = 0;
        end else if (!m_active) begin
            if (s) begin
                m_active = 1; m_idx = 0; m_gap = 0; m_lfsr = SEED; m_mode = md;
            end
        end else if (m_gap > 0) begin
            m_gap--;
        end else if (rd) begin
            m_lfsr = lfsr_adv(m_lfsr);
            m_idx++;
            if (m_idx == int'(TOTAL)) begin
                m_active = 0; m_done = 1;
            end else if (m_idx % int'(PAYLOAD) == 0) begin
                m_gap = int'(GAP);
            end
        end
        e_valid = m_active && (m_gap == 0);
        e_busy  = m_active;
        e_done  = m_done;
        e_sop   = e_valid && (m_idx % int'(PAYLOAD) == 0);
        e_eop   = e_valid && (m_idx % int'(PAYLOAD) == int'(PAYLOAD) - 1);
        if (e_valid) m_flit = pat(m_mode, m_idx % int'(PAYLOAD), m_lfsr);
    endtask

    // Advance the model on each edge with the inputs the DUT saw, then compare just after.
    always @(posedge clk) begin
        model_step(rst, start, mode, ready);
        #1;
        chk("valid", 64'(valid), 64'(e_valid));
        chk("sop", 64'(sop), 64'(e_sop));
        chk("eop", 64'(eop), 64'(e_eop));
        chk("busy", 64'(busy), 64'(e_busy));
        chk("done", 64'(done), 64'(e_done));
        chk("operand_a", 64'(operand_a), 64'(m_flit[N-1:0]));
        chk("operand_b", 64'(operand_b), 64'(m_flit[W-1:N]));
    end

    // ---------------- run driver with per-cycle recording ----------------
    logic [N-1:0] rec_a [MAXREC];
    logic [N-1:0] rec_b [MAXREC];
    bit rec_valid [MAXREC];
    bit rec_sop [MAXREC];
    bit rec_eop [MAXREC];
    bit rec_busy [MAXREC];
    bit rec_done [MAXREC];
    int done_rel, vcount, ndone;

    // rel = cycle number counted from the cycle in which start is high.
    task automatic run(input logic [1:0] md, input int stall_at, input int stall_len,
                       input int rst_at, input bit rnd, input bit disturb);
        done_rel = -1; vcount = 0; ndone = 0;
        for (int rel = 0; rel < MAXREC; rel++) begin
            @(negedge clk);
            rec_a[rel] = operand_a; rec_b[rel] = operand_b;
            rec_valid[rel] = valid; rec_sop[rel] = sop; rec_eop[rel] = eop;
            rec_busy[rel] = busy; rec_done[rel] = done;
            if (valid) vcount++;
            if (done) begin
                ndone++;
                if (done_rel < 0) done_rel = rel;
            end
            if (done_rel >= 0 && rel > done_rel) break;
            if (rst_at >= 0 && rel > rst_at + 1) break;
            start = (rel == 0) || (disturb && done_rel < 0 && $urandom_range(0, 3) == 0);
            mode  = (rel == 0 || !disturb) ? md : 2'($urandom);
            ready = rnd ? ($urandom_range(0, 3) != 0)
                        : !(rel >= stall_at && rel < stall_at + stall_len);
            rst   = (rel == rst_at);
        end
        start = 1'b0; rst = 1'b0; ready = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_valid", 64'(valid), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_a", 64'(operand_a), 64'd0);
        chk("reset_b", 64'(operand_b), 64'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Thermometer, full-rate run
        run(2'd1, -1, 0, -1, 1'b0, 1'b0);
        chk("therm_idle_c0", 64'(rec_valid[0]), 64'd0);
        chk("therm_f0_valid", 64'(rec_valid[1]), 64'd1);
        chk("therm_f0_sop", 64'(rec_sop[1]), 64'd1);
        chk("therm_f0_a", 64'(rec_a[1]), 64'h00000);
        chk("therm_f0_b", 64'(rec_b[1]), 64'h00000);
        chk("therm_f1_a", 64'(rec_a[2]), 64'h00001);
        chk("therm_f17_a", 64'(rec_a[18]), 64'h1FFFF);
        chk("therm_f17_b", 64'(rec_b[18]), 64'h00000);
        chk("therm_f19_a", 64'(rec_a[20]), 64'h1FFFF);
        chk("therm_f19_b", 64'(rec_b[20]), 64'h00003);
        chk("therm_f19_eop", 64'(rec_eop[20]), 64'd1);
        chk("therm_gap_first", 64'(rec_valid[21]), 64'd0);
        chk("therm_gap_last", 64'(rec_valid[27]), 64'd0);
        chk("therm_gap_busy", 64'(rec_busy[24]), 64'd1);
        chk("therm_p1_valid", 64'(rec_valid[28]), 64'd1);
        chk("therm_p1_sop", 64'(rec_sop[28]), 64'd1);
        chk("therm_last_eop", 64'(rec_eop[263]), 64'd1);
        chk("therm_done_cycle", 64'(done_rel), 64'd264);
        chk("therm_done_count", 64'(ndone), 64'd1);
        chk("therm_busy_264", 64'(rec_busy[264]), 64'd0);
        chk("therm_valid_count", 64'(vcount), 64'd200);

        // LFSR from SEED
        run(2'd0, -1, 0, -1, 1'b0, 1'b0);
        chk("lfsr_f0_a", 64'(rec_a[1]), 64'h00001);
        chk("lfsr_f1_a", 64'(rec_a[2]), 64'h00003);
        chk("lfsr_f2_a", 64'(rec_a[3]), 64'h00006);
        chk("lfsr_f2_b", 64'(rec_b[3]), 64'h00000);
        chk("lfsr_p1_not_restart", 64'(rec_a[28] == 17'h00001), 64'd0);

        // Alternating with a 3-cycle stall on flit 5
        run(2'd2, 6, 3, -1, 1'b0, 1'b0);
        chk("alt_f5_a", 64'(rec_a[6]), 64'h1FFFF);
        chk("alt_stall_valid", 64'(rec_valid[8]), 64'd1);
        chk("alt_stall_a", 64'(rec_a[8]), 64'h1FFFF);
        chk("alt_stall_b", 64'(rec_b[9]), 64'h1FFFF);
        chk("alt_f6_a", 64'(rec_a[10]), 64'h00000);
        chk("alt_done_cycle", 64'(done_rel), 64'd267);

        // Reset during packet 3 flit 8, then a fresh LFSR run
        run(2'd0, -1, 0, 63, 1'b0, 1'b0);
        chk("rst_pre_valid", 64'(rec_valid[63]), 64'd1);
        chk("rst_p2_sop", 64'(rec_sop[55]), 64'd1);
        chk("rst_valid", 64'(rec_valid[64]), 64'd0);
        chk("rst_busy", 64'(rec_busy[64]), 64'd0);
        chk("rst_a", 64'(rec_a[64]), 64'd0);
        chk("rst_done", 64'(ndone), 64'd0);
        run(2'd0, -1, 0, -1, 1'b0, 1'b0);
        chk("rerun_f0_a", 64'(rec_a[1]), 64'h00001);

        // start and mode toggled mid-run must not disturb the run
        run(2'd1, -1, 0, -1, 1'b0, 1'b1);
        chk("disturb_done_cycle", 64'(done_rel), 64'd264);
        chk("disturb_valid_count", 64'(vcount), 64'd200);

        // Random back-pressure across modes
        for (int m = 0; m < 4; m++) begin
            run(2'(m), -1, 0, -1, 1'b1, 1'b0);
            chk("rnd_done_count", 64'(ndone), 64'd1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
